lc4_decode_stage: RTL

//  LC4 pipeline decode stage: holds the F/D latch, decodes it, and drives the register file's rs/rt selectors.

---
 rtl/lc4_pipe_pkg.sv | 44 ++++
 rtl/lc4_decoder.sv | 73 +++++++
 rtl/lc4_decode_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/lc4_pipe_pkg.sv
// Shared LC4 pipeline definitions: ISA opcodes, reset constants and decoded-control records.
package lc4_pipe_pkg;

    localparam logic [15:0] LC4_NOP    = 16'h0000;
    localparam logic [15:0] LC4_RST_PC = 16'h8200;

    localparam logic [3:0] OP_BR      = 4'h0;
    localparam logic [3:0] OP_ARITH   = 4'h1;
    localparam logic [3:0] OP_CMP     = 4'h2;
    localparam logic [3:0] OP_JSR     = 4'h4;
    localparam logic [3:0] OP_LOGIC   = 4'h5;
    localparam logic [3:0] OP_LDR     = 4'h6;
    localparam logic [3:0] OP_STR     = 4'h7;
    localparam logic [3:0] OP_RTI     = 4'h8;
    localparam logic [3:0] OP_CONST   = 4'h9;
    localparam logic [3:0] OP_SHIFT   = 4'hA;
    localparam logic [3:0] OP_JMP     = 4'hC;
    localparam logic [3:0] OP_HICONST = 4'hD;
    localparam logic [3:0] OP_TRAP    = 4'hF;

    typedef struct packed {
        logic [2:0] rs_sel;
        logic [2:0] rt_sel;
        logic [2:0] rd_sel;
        logic       rs_re;
        logic       rt_re;
        logic       rd_we;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } lc4_ctl_t;

    // Subset carried into D/X; read enables only matter for hazard detection in decode.
    typedef struct packed {
        logic [2:0] rs_sel;
        logic [2:0] rt_sel;
        logic [2:0] rd_sel;
        logic       rd_we;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
    } lc4_dx_ctl_t;

endpackage

// File: rtl/lc4_decoder.sv
// Pure combinational LC4 instruction decoder: 16-bit insn -> register selectors and control flags.
module lc4_decoder
    import lc4_pipe_pkg::*;
(
    input  logic [15:0] i_insn,
    output lc4_ctl_t    o_ctl
);

    always_comb begin
        // NOTE: every field gets a default first so no path through the case can infer a latch.
        o_ctl        = '0;
        o_ctl.rs_sel = i_insn[8:6];
        o_ctl.rt_sel = i_insn[2:0];
        o_ctl.rd_sel = i_insn[11:9];
        case (i_insn[15:12])
            // BR with an empty NZP mask (including NOP) never consults the condition codes.
            OP_BR:      o_ctl.is_branch = (i_insn[11:9] != 3'b000);
            OP_ARITH: begin
                o_ctl.rs_re = 1'b1;
                o_ctl.rt_re = ~i_insn[5];
                o_ctl.rd_we = 1'b1;
            end
            OP_CMP: begin
                o_ctl.rs_sel = i_insn[11:9];
                o_ctl.rs_re  = 1'b1;
                o_ctl.rt_re  = ~i_insn[8];
            end
            OP_JSR: begin
                o_ctl.rs_re  = ~i_insn[11];
                o_ctl.rd_sel = 3'd7;
                o_ctl.rd_we  = 1'b1;
            end
            OP_LOGIC: begin
                o_ctl.rs_re = 1'b1;
                o_ctl.rt_re = ~i_insn[5] && (i_insn[4:3] != 2'b01);
                o_ctl.rd_we = 1'b1;
            end
            OP_LDR: begin
                o_ctl.rs_re   = 1'b1;
                o_ctl.rd_we   = 1'b1;
                o_ctl.is_load = 1'b1;
            end
            OP_STR: begin
                o_ctl.rt_sel   = i_insn[11:9];
                o_ctl.rs_re    = 1'b1;
                o_ctl.rt_re    = 1'b1;
                o_ctl.is_store = 1'b1;
            end
            OP_RTI: begin
                o_ctl.rs_sel = 3'd7;
                o_ctl.rs_re  = 1'b1;
            end
            OP_CONST:   o_ctl.rd_we = 1'b1;
            OP_SHIFT: begin
                o_ctl.rs_re = 1'b1;
                o_ctl.rt_re = (i_insn[5:4] == 2'b11);
                o_ctl.rd_we = 1'b1;
            end
            OP_JMP:     o_ctl.rs_re = ~i_insn[11];
            OP_HICONST: begin
                o_ctl.rs_sel = i_insn[11:9];
                o_ctl.rs_re  = 1'b1;
                o_ctl.rd_we  = 1'b1;
            end
            OP_TRAP: begin
                o_ctl.rd_sel = 3'd7;
                o_ctl.rd_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc4_decode_stage.sv
// LC4 decode stage: F/D latch, decode, WD bypass, load-use stall, flush and D/X latch.
// Optional stall/flush performance counters are built when LC4_DECODE_PERF_EN is defined.
module lc4_decode_stage
    import lc4_pipe_pkg::*;
#(
    parameter int            n      = 16,
    parameter logic [n-1:0]  RST_PC = n'(LC4_RST_PC)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         gwe,
    input  logic [n-1:0] i_f_insn,
    input  logic [n-1:0] i_f_pc,
    input  logic         i_f_valid,
    output logic         o_stall,
    input  logic         i_flush,
    output logic [2:0]   o_rs_sel,
    output logic [2:0]   o_rt_sel,
    input  logic [n-1:0] i_rs_data,
    input  logic [n-1:0] i_rt_data,
    input  logic [2:0]   i_w_rd,
    input  logic         i_w_we,
    input  logic [n-1:0] i_w_data,
    output logic         o_dx_valid,
    output logic [n-1:0] o_dx_insn,
    output logic [n-1:0] o_dx_pc,
    output logic [2:0]   o_dx_rs_sel,
    output logic [2:0]   o_dx_rt_sel,
    output logic [2:0]   o_dx_rd_sel,
    output logic [n-1:0] o_dx_rs_data,
    output logic [n-1:0] o_dx_rt_data,
    output logic         o_dx_rd_we,
    output logic         o_dx_is_load,
    output logic         o_dx_is_store,
    output logic         o_dx_is_branch,
    output logic [15:0]  o_stall_cnt,
    output logic [15:0]  o_flush_cnt
);

    localparam logic [n-1:0] NOP = n'(LC4_NOP);

    logic              fd_valid_q, fd_valid_d;
    logic [n-1:0]      fd_insn_q, fd_insn_d;
    logic [n-1:0]      fd_pc_q, fd_pc_d;
    logic              dx_valid_q, dx_valid_d;
    logic [n-1:0]      dx_insn_q, dx_insn_d;
    logic [n-1:0]      dx_pc_q, dx_pc_d;
    lc4_dx_ctl_t       dx_ctl_q, dx_ctl_d;
    logic [n-1:0]      dx_rs_data_q, dx_rs_data_d;
    logic [n-1:0]      dx_rt_data_q, dx_rt_data_d;

    lc4_ctl_t          fd_ctl;
    logic [n-1:0]      rs_byp, rt_byp;
    logic              load_use;

    lc4_decoder u_decoder (
        .i_insn (fd_insn_q[15:0]),
        .o_ctl  (fd_ctl)
    );

    // The regfile returns the old value during its own write cycle, so forward WD here.
    assign rs_byp = (i_w_we && i_w_rd == fd_ctl.rs_sel) ? i_w_data : i_rs_data;
    assign rt_byp = (i_w_we && i_w_rd == fd_ctl.rt_sel) ? i_w_data : i_rt_data;

    // A store's data operand is consumed late enough to be forwarded after the load.
    assign load_use = fd_valid_q && dx_valid_q && dx_ctl_q.is_load && dx_ctl_q.rd_we &&
                      ((fd_ctl.rs_re && fd_ctl.rs_sel == dx_ctl_q.rd_sel) ||
                       (fd_ctl.rt_re && fd_ctl.rt_sel == dx_ctl_q.rd_sel && !fd_ctl.is_store) ||
                       fd_ctl.is_branch);

    assign o_stall = load_use && !i_flush;

    always_comb begin
        fd_valid_d = fd_valid_q;
        fd_insn_d  = fd_insn_q;
        fd_pc_d    = fd_pc_q;
        if (i_flush) begin
            fd_valid_d = 1'b0;
            fd_insn_d  = NOP;
            fd_pc_d    = RST_PC;
        end else if (!o_stall) begin
            fd_valid_d = i_f_valid;
            fd_insn_d  = i_f_valid ? i_f_insn : NOP;
            fd_pc_d    = i_f_valid ? i_f_pc : RST_PC;
        end

        dx_valid_d   = 1'b0;
        dx_insn_d    = NOP;
        dx_pc_d      = RST_PC;
        dx_ctl_d     = '0;
        dx_rs_data_d = '0;
        dx_rt_data_d = '0;
        if (!i_flush && !o_stall && fd_valid_q) begin
            dx_valid_d         = 1'b1;
            dx_insn_d          = fd_insn_q;
            dx_pc_d            = fd_pc_q;
            dx_ctl_d.rs_sel    = fd_ctl.rs_sel;
            dx_ctl_d.rt_sel    = fd_ctl.rt_sel;
            dx_ctl_d.rd_sel    = fd_ctl.rd_sel;
            dx_ctl_d.rd_we     = fd_ctl.rd_we;
            dx_ctl_d.is_load   = fd_ctl.is_load;
            dx_ctl_d.is_store  = fd_ctl.is_store;
            dx_ctl_d.is_branch = fd_ctl.is_branch;
            dx_rs_data_d       = rs_byp;
            dx_rt_data_d       = rt_byp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_valid_q   <= 1'b0;
            fd_insn_q    <= NOP;
            fd_pc_q      <= RST_PC;
            dx_valid_q   <= 1'b0;
            dx_insn_q    <= NOP;
            dx_pc_q      <= RST_PC;
            dx_ctl_q     <= '0;
            dx_rs_data_q <= '0;
            dx_rt_data_q <= '0;
        end else if (gwe) begin
            // NOTE: non-blocking updates so every latch samples the pre-edge values of the others.
            fd_valid_q   <= fd_valid_d;
            fd_insn_q    <= fd_insn_d;
            fd_pc_q      <= fd_pc_d;
            dx_valid_q   <= dx_valid_d;
            dx_insn_q    <= dx_insn_d;
            dx_pc_q      <= dx_pc_d;
            dx_ctl_q     <= dx_ctl_d;
            dx_rs_data_q <= dx_rs_data_d;
            dx_rt_data_q <= dx_rt_data_d;
        end
    end

`ifdef LC4_DECODE_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (o_stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (i_flush && fd_valid_q && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else if (gwe) begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = 16'h0000;
    assign o_flush_cnt = 16'h0000;
`endif

    assign o_rs_sel       = fd_ctl.rs_sel;
    assign o_rt_sel       = fd_ctl.rt_sel;
    assign o_dx_valid     = dx_valid_q;
    assign o_dx_insn      = dx_insn_q;
    assign o_dx_pc        = dx_pc_q;
    assign o_dx_rs_sel    = dx_ctl_q.rs_sel;
    assign o_dx_rt_sel    = dx_ctl_q.rt_sel;
    assign o_dx_rd_sel    = dx_ctl_q.rd_sel;
    assign o_dx_rs_data   = dx_rs_data_q;
    assign o_dx_rt_data   = dx_rt_data_q;
    assign o_dx_rd_we     = dx_ctl_q.rd_we;
    assign o_dx_is_load   = dx_ctl_q.is_load;
    assign o_dx_is_store  = dx_ctl_q.is_store;
    assign o_dx_is_branch = dx_ctl_q.is_branch;

endmodule
